// File: rtl/cakegame_pkg.sv
// cakegame_pkg: shared types, defaults and helpers for the cake game input path
//   state_t    : FSM state encoding, exported on db_state for debug display
//   is_one_hot : true when exactly one bit of the (zero-extended) vector is set
package cakegame_pkg;

   localparam int N_BUTTONS_DEF = 4;

   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_DEBOUNCE     = 3'd1,
      S_PRESSED      = 3'd2,
      S_WAIT_RELEASE = 3'd3
   } state_t;

   function automatic logic is_one_hot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/cakegame_sync.sv
// cakegame_sync: two-flop synchronizer for a bus of independent asynchronous levels
//   clock, reset : rising-edge clock, synchronous active-high reset
//   d            : asynchronous input levels
//   q            : synchronized levels, two edges after d
module cakegame_sync #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] s1;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1 <= '0;
         q  <= '0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/cakegame_play_input.sv
// cakegame_play_input: debounced play-button front end with play check and timeout
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   buttons       : raw button levels, 1 = pressed
//   enable        : accept plays and run the timeout counter
//   clear_play    : clears play_code/correct_play, wins over a same-edge capture
//   expected_play : one-hot play expected by sequence memory
//   has_play      : one-cycle pulse per accepted press
//   play_code     : last accepted press, held
//   correct_play  : play_code matched expected_play at acceptance, held
//   timeout       : high while enabled and the timeout count is saturated
//   db_state      : current FSM state
module cakegame_play_input
   import cakegame_pkg::*;
#(
   parameter int N_BUTTONS       = N_BUTTONS_DEF,
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int TIMEOUT_CYCLES  = 10
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N_BUTTONS-1:0] buttons,
   input  logic                 enable,
   input  logic                 clear_play,
   input  logic [N_BUTTONS-1:0] expected_play,
   output logic                 has_play,
   output logic [N_BUTTONS-1:0] play_code,
   output logic                 correct_play,
   output logic                 timeout,
   output logic [2:0]           db_state
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT_CYCLES);

   state_t               state, state_n;
   logic [N_BUTTONS-1:0] btn_s, cand, cand_n;
   logic [DW-1:0]        deb_cnt, deb_n, rel_cnt, rel_n;
   logic [TW-1:0]        tcnt;
   logic                 capture;

   cakegame_sync #(.W(N_BUTTONS)) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (buttons),
      .q     (btn_s)
   );

   assign has_play = (state == S_PRESSED);
   assign timeout  = enable && (tcnt == T_MAX);
   assign db_state = state;

   always_comb begin
      state_n = state;
      cand_n  = cand;
      deb_n   = deb_cnt;
      rel_n   = rel_cnt;
      capture = 1'b0;
      case (state)
         S_IDLE:
            if (is_one_hot(32'(btn_s))) begin
               cand_n  = btn_s;
               deb_n   = '0;
               state_n = S_DEBOUNCE;
            end
         S_DEBOUNCE:
            if (btn_s != cand)
               state_n = S_IDLE;
            else if (deb_cnt == DEB_LAST) begin
               // a press that stabilizes while disabled is swallowed until released
               state_n = enable ? S_PRESSED : S_WAIT_RELEASE;
               capture = enable;
               rel_n   = '0;
            end else
               deb_n = deb_cnt + 1'b1;
         S_PRESSED: begin
            state_n = S_WAIT_RELEASE;
            rel_n   = '0;
         end
         S_WAIT_RELEASE:
            if (btn_s != '0)
               rel_n = '0;
            else if (rel_cnt == DEB_LAST)
               state_n = S_IDLE;
            else
               rel_n = rel_cnt + 1'b1;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_IDLE;
         cand         <= '0;
         deb_cnt      <= '0;
         rel_cnt      <= '0;
         play_code    <= '0;
         correct_play <= 1'b0;
         tcnt         <= '0;
      end else begin
         state   <= state_n;
         cand    <= cand_n;
         deb_cnt <= deb_n;
         rel_cnt <= rel_n;
         if (clear_play) begin
            play_code    <= '0;
            correct_play <= 1'b0;
         end else if (capture) begin
            play_code    <= cand;
            correct_play <= (cand == expected_play);
         end
         // counting pauses while a press is being qualified
         if (!enable || has_play)
            tcnt <= '0;
         else if (state != S_DEBOUNCE && tcnt != T_MAX)
            tcnt <= tcnt + 1'b1;
      end
   end

endmodule
